// File: rtl/draw_bounce_multi.sv
// Multi-box bouncing renderer for the VGA pixel path.
// Boxes move once per frame, bounce off the field edges, and the block emits a registered pixel colour.
module draw_bounce_multi #(
  parameter int NUM_BOX      = 2,
  parameter int BOX_W        = 36,
  parameter int BOX_H        = 36,
  parameter int PORCH_LEFT   = 144,
  parameter int PORCH_RIGHT  = 784,
  parameter int PORCH_TOP    = 36,
  parameter int PORCH_BOTTOM = 500,
  parameter int STEP         = 1,
  parameter logic [8*NUM_BOX-1:0] BOX_COLORS = 16'h1CA5,
  parameter logic [7:0] FIELD_COLOR = 8'hCE
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        run,
  output logic [7:0]  rgb,
  output logic        frame_tick,
  output logic [15:0] bounce_cnt
);

  localparam logic [10:0] X_LO = 11'(PORCH_LEFT);
  localparam logic [10:0] X_HI = 11'(PORCH_RIGHT - 1 - BOX_W);
  localparam logic [10:0] Y_LO = 11'(PORCH_TOP);
  localparam logic [10:0] Y_HI = 11'(PORCH_BOTTOM - 1 - BOX_H);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       flip;
  } axis_t;

  function automatic logic [9:0] init_x(input int i);
    return 10'(PORCH_LEFT + 2 + i * (BOX_W + 4));
  endfunction

  function automatic logic [9:0] init_y(input int i);
    return 10'(PORCH_TOP + 2 + i * (BOX_H + 4));
  endfunction

  function automatic bit cfg_ok();
    bit ok;
    ok = (NUM_BOX >= 1) && (NUM_BOX <= 4);
    for (int i = 0; i < NUM_BOX; i++) begin
      if ((PORCH_LEFT + 2 + i * (BOX_W + 4) > PORCH_RIGHT - 1 - BOX_W) ||
          (PORCH_TOP + 2 + i * (BOX_H + 4) > PORCH_BOTTOM - 1 - BOX_H)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  localparam bit CFG_OK = cfg_ok();

  if (!CFG_OK) begin : g_bad_cfg
    $error("draw_bounce_multi: box count or initial positions outside motion limits");
  end

  // One axis of motion: clamp to the limit and reverse when the step would reach or pass it.
  function automatic axis_t axis_next(input logic [9:0] pos, input logic dir,
                                      input logic [10:0] step, input logic [10:0] lo,
                                      input logic [10:0] hi);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] sum;
    logic [10:0] diff;
    p    = {1'b0, pos};
    sum  = p + step;
    diff = p - step;
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    if (!dir) begin
      if (sum >= hi) begin
        r.pos  = hi[9:0];
        r.dir  = 1'b1;
        r.flip = 1'b1;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      if (p <= lo + step) begin
        r.pos  = lo[9:0];
        r.dir  = 1'b0;
        r.flip = 1'b1;
      end else begin
        r.pos = diff[9:0];
      end
    end
    return r;
  endfunction

  logic [9:0]  box_x [NUM_BOX];
  logic [9:0]  box_y [NUM_BOX];
  logic [NUM_BOX-1:0] dir_x;
  logic [NUM_BOX-1:0] dir_y;
  logic        match_r;
  logic        match;
  logic        trigger;
  axis_t       nx_x [NUM_BOX];
  axis_t       nx_y [NUM_BOX];
  logic [3:0]  flips;
  logic [16:0] bounce_sum;
  logic [15:0] bounce_nxt;
  logic [7:0]  pix;
  logic [10:0] hx;
  logic [10:0] vy;

  assign match   = (h_count == 10'd1) && (v_count == 10'd1);
  assign trigger = match && !match_r;
  assign hx      = {1'b0, h_count};
  assign vy      = {1'b0, v_count};

  // Next positions/directions for every box and the number of flips this frame.
  always_comb begin
    flips = 4'd0;
    for (int i = 0; i < NUM_BOX; i++) begin
      nx_x[i] = axis_next(box_x[i], dir_x[i], 11'(STEP + i), X_LO, X_HI);
      nx_y[i] = axis_next(box_y[i], dir_y[i], 11'(STEP), Y_LO, Y_HI);
      flips   = flips + {3'd0, nx_x[i].flip} + {3'd0, nx_y[i].flip};
    end
    bounce_sum = {1'b0, bounce_cnt} + {13'd0, flips};
    if (bounce_sum[16]) begin
      bounce_nxt = 16'hFFFF;
    end else begin
      bounce_nxt = bounce_sum[15:0];
    end
  end

  // Pixel colour: field background, then boxes painted highest index first so index 0 wins.
  always_comb begin
    if ((hx >= 11'(PORCH_LEFT)) && (hx < 11'(PORCH_RIGHT)) &&
        (vy >= 11'(PORCH_TOP)) && (vy < 11'(PORCH_BOTTOM))) begin
      pix = FIELD_COLOR;
    end else begin
      pix = 8'h00;
    end
    for (int i = NUM_BOX - 1; i >= 0; i--) begin
      if ((hx >= {1'b0, box_x[i]}) && (hx < {1'b0, box_x[i]} + 11'(BOX_W)) &&
          (vy >= {1'b0, box_y[i]}) && (vy < {1'b0, box_y[i]} + 11'(BOX_H))) begin
        pix = BOX_COLORS[8*i +: 8];
      end else begin
        pix = pix;
      end
    end
  end

  // State, frame edge detection and registered outputs.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      match_r    <= 1'b0;
      frame_tick <= 1'b0;
      rgb        <= 8'h00;
      bounce_cnt <= 16'h0000;
      dir_x      <= '0;
      dir_y      <= '0;
      for (int i = 0; i < NUM_BOX; i++) begin
        box_x[i] <= init_x(i);
        box_y[i] <= init_y(i);
      end
    end else begin
      match_r    <= match;
      frame_tick <= trigger;
      rgb        <= pix;
      if (trigger && run) begin
        bounce_cnt <= bounce_nxt;
        for (int i = 0; i < NUM_BOX; i++) begin
          box_x[i] <= nx_x[i].pos;
          box_y[i] <= nx_y[i].pos;
          dir_x[i] <= nx_x[i].dir;
          dir_y[i] <= nx_y[i].dir;
        end
      end else begin
        bounce_cnt <= bounce_cnt;
      end
    end
  end

endmodule

// File: doc/draw_bounce_multi.md
# draw_bounce_multi

Parametrised successor to the single bouncing-box renderer in the VGA pixel path. It animates NUM_BOX independent boxes inside a rectangular field and bounces them off the field edges, moving them once per frame at per-box speeds. Each cycle it produces a registered 8-bit RGB pixel from the incoming h_count/v_count raster position. It also reports a frame strobe and a saturating wall-bounce counter for status LEDs and the seven-segment display.

## Interface
- NUM_BOX, 2, number of boxes; 1..4
- BOX_W, 36, box width in pixels
- BOX_H, 36, box height in pixels
- PORCH_LEFT, 144, first column of the field
- PORCH_RIGHT, 784, first column past the field
- PORCH_TOP, 36, first row of the field
- PORCH_BOTTOM, 500, first row past the field
- STEP, 1, base motion step in pixels per frame
- BOX_COLORS, {8'h1C, 8'hA5}, NUM_BOX*8-bit colour vector; box i uses bits [8i+7:8i]
- FIELD_COLOR, 8'hCE, colour inside the field where no box is drawn
- clk_25  in  1  25 MHz pixel clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- h_count  in  10  raster column
- v_count  in  10  raster row
- run  in  1  1 = boxes move at frame update; 0 = positions and directions frozen
- rgb  out  8  registered pixel colour
- frame_tick  out  1  one-cycle pulse per frame update
- bounce_cnt  out  16  total wall bounces; saturates at 16'hFFFF

## Operation
- Per-box state:
  - box_x[i], box_y[i]: 10 bits each, top-left corner
  - dir_x[i], dir_y[i]: 0 = increasing, 1 = decreasing
- Box step sizes:
  - X step of box i = STEP + i
  - Y step of box i = STEP
- Reset state:
  - box_x[i] = PORCH_LEFT + 2 + i*(BOX_W+4)
  - box_y[i] = PORCH_TOP + 2 + i*(BOX_H+4)
  - all dir = 0
  - rgb = 0, frame_tick = 0, bounce_cnt = 0
- Frame update trigger:
  - Fires on the first cycle where (h_count == 1 and v_count == 1) and the previous cycle did not match. This edge detection needs a 1-bit registered match flag, which resets to 0.
  - Holding (1,1) for several cycles gives exactly one update.
- On a trigger, frame_tick = 1 on the next cycle, regardless of run.
- If run = 1, each axis of each box updates at the trigger. X axis uses limits lo = PORCH_LEFT, hi = PORCH_RIGHT - 1 - BOX_W; Y axis uses lo = PORCH_TOP, hi = PORCH_BOTTOM - 1 - BOX_H:
  - Increasing: if pos + step >= hi, then pos <= hi, flip direction, count 1 bounce. Otherwise pos <= pos + step.
  - Decreasing: if pos <= lo + step, then pos <= lo, flip direction, count 1 bounce. Otherwise pos <= pos - step.
  - All comparisons are done in 11 bits; no wrap-around.
- bounce_cnt adds the number of axis flips in the update (0..2*NUM_BOX), clamped to 16'hFFFF.
- Rendering:
  - A box covers h in [box_x, box_x+BOX_W) and v in [box_y, box_y+BOX_H).
  - Where boxes overlap, the lowest index wins.
  - If no box covers the pixel and it lies in [PORCH_LEFT, PORCH_RIGHT) x [PORCH_TOP, PORCH_BOTTOM), rgb = FIELD_COLOR; otherwise rgb = 0.
- Boxes never overlap each other's motion; overlap affects only drawing priority.
- Elaboration constraint: initial positions must lie within the limits. Violations are a configuration error.

## Timing
- rgb has 1-cycle latency: rgb at cycle n+1 reflects h_count/v_count at cycle n and the box positions held at cycle n.
- Positions change on the cycle after the trigger. Frames are tear-free because row 1 lies outside the field.
- frame_tick and the new positions become visible in the same cycle. bounce_cnt updates in that cycle too.
- Reset mid-frame:
  - The next cycle shows all reset values.
  - A trigger coincident with rst is ignored.
  - The edge flag clears, so (1,1) still held after reset release triggers once.

## Test plan
- Reset, then pulse (1,1):
  - Immediately after reset: rgb = 0, bounce_cnt = 0, box0 at (146,38), box1 at (186,78).
  - Drive (146,38) -> rgb = 8'hA5 one cycle later.
  - Drive (186,78) -> 8'h1C.
  - Drive (300,300) -> 8'hCE.
  - Drive (10,10) -> 8'h00.
- Hold (1,1) for 5 cycles -> exactly one frame_tick. Box0 moves to (147,39) and box1 to (188,79): (146,38) now -> 8'hCE, (147,39) -> 8'hA5.
- 425 frame triggers with run = 1:
  - Box1 x clamps to 747 at frame 281.
  - Box1 y clamps to 463 at frame 385.
  - Box0 y clamps to 463 at frame 425.
  - Result: bounce_cnt = 3, box1 x = 459.
- run = 0 for 10 triggers -> 10 frame_ticks, positions and bounce_cnt unchanged.
- Force overlap (NUM_BOX = 2, same initial row via parameters) -> overlapping pixels = 8'hA5.
- Preload bounce_cnt near saturation (bench force at 16'hFFFE), then trigger a frame with 2 flips -> 16'hFFFF, and it holds.
- Assert rst mid-frame while (1,1) is held -> reset values, followed by one update after release.
